// File: rtl/axis_sample_packer_pkg.sv
// Shared constants and helpers for the serial-to-parallel sample packer.
package axis_sample_packer_pkg;

  // Width of the m_axis tuser sideband (carries the frame tag when enabled).
  localparam int TUSER_W = 8;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_sample_packer.sv
// axis_sample_packer: packs a serial real-sample AXI-Stream into packets of
// SAMP_PER_CLK complex lanes (re = sample, im = 0), with tlast on the last
// packet of each FFT_LEN-sample frame.
// Lane layout of m_axis_tdata[i]: {im, re}, each WIDTH bits.
// Optional: define SAMPLE_PACKER_FRAME_TAG_EN to carry a frame counter on tuser.
module axis_sample_packer
  import axis_sample_packer_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int SAMP_PER_CLK = 4,
  parameter int FFT_LEN      = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [WIDTH-1:0]                        s_axis_tdata,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  output logic [SAMP_PER_CLK-1:0][2*WIDTH-1:0]    m_axis_tdata,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tlast,
  output logic [TUSER_W-1:0]                      m_axis_tuser
);

  localparam int NPKT   = FFT_LEN / SAMP_PER_CLK;
  localparam int LANE_W = cnt_w(SAMP_PER_CLK);
  localparam int PKT_W  = cnt_w(NPKT);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SAMP_PER_CLK - 1);
  localparam logic [PKT_W-1:0]  LAST_PKT  = PKT_W'(NPKT - 1);

  logic [LANE_W-1:0]                     lane_cnt;
  logic [PKT_W-1:0]                      pkt_cnt;
  logic                                  out_vld;
  logic                                  out_last;
  logic [SAMP_PER_CLK-1:0][2*WIDTH-1:0]  asm_q;
  logic [SAMP_PER_CLK-1:0][2*WIDTH-1:0]  out_q;
  logic [SAMP_PER_CLK-1:0][2*WIDTH-1:0]  pkt_next;
  logic [2*WIDTH-1:0]                    samp_cx;
  logic                                  last_lane;
  logic                                  accept;
  logic                                  pkt_done;

  assign samp_cx   = {{WIDTH{1'b0}}, s_axis_tdata};
  assign last_lane = (lane_cnt == LAST_LANE);
  // Only the final lane of a packet needs room in the output register, so
  // earlier lanes keep flowing even while the output is stalled.
  assign s_axis_tready = rst & (~last_lane | ~out_vld | m_axis_tready);
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign pkt_done  = accept & last_lane;

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_q;
  assign m_axis_tlast  = out_last;

  // Completed packet: stored lanes plus the sample arriving into the last lane.
  always_comb begin
    pkt_next = asm_q;
    pkt_next[SAMP_PER_CLK-1] = samp_cx;
  end

  // Lane assembly and lane counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt <= '0;
      asm_q    <= '0;
    end else if (accept) begin
      asm_q[lane_cnt] <= samp_cx;
      lane_cnt        <= last_lane ? '0 : lane_cnt + LANE_W'(1);
    end
  end

  // Output register, valid flag and per-frame packet counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      pkt_cnt  <= '0;
    end else if (pkt_done) begin
      out_q    <= pkt_next;
      out_vld  <= 1'b1;
      out_last <= (pkt_cnt == LAST_PKT);
      pkt_cnt  <= (pkt_cnt == LAST_PKT) ? '0 : pkt_cnt + PKT_W'(1);
    end else if (m_axis_tready) begin
      out_vld  <= 1'b0;
    end
  end

`ifdef SAMPLE_PACKER_FRAME_TAG_EN
  logic [TUSER_W-1:0] frame_cnt;
  logic [TUSER_W-1:0] tuser_q;

  // Tag each packet with its frame number; advance after the frame's tlast packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      tuser_q   <= '0;
    end else if (pkt_done) begin
      tuser_q <= frame_cnt;
      if (pkt_cnt == LAST_PKT) frame_cnt <= frame_cnt + TUSER_W'(1);
    end
  end

  assign m_axis_tuser = tuser_q;
`else
  assign m_axis_tuser = '0;
`endif

endmodule
